// File: rtl/gelato_inst_buffer_pkg.sv
// Shared types and constants for the gelato per-warp instruction buffer.
//   warp_num_t    : warp index, width sets the number of warps (2**WARP_W)
//   addr_t        : instruction address
//   gelato_inst_t : decoded instruction word
//   ibuf_entry_t  : one buffered slot, instruction plus its PC
//   iss_state_e   : issue-side lock state
package gelato_inst_buffer_pkg;

    localparam int WARP_W        = 4;
    localparam int NUM_WARPS_DEF = 2 ** WARP_W;
    localparam int IBUF_DEPTH    = 2;

    typedef logic [WARP_W-1:0] warp_num_t;
    typedef logic [31:0]       addr_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [9:0] imm;
    } gelato_inst_t;

    typedef struct packed {
        gelato_inst_t inst;
        addr_t        pc;
    } ibuf_entry_t;

    typedef enum logic {
        ISS_FREE   = 1'b0,
        ISS_LOCKED = 1'b1
    } iss_state_e;

    // Next warp in round-robin order; wraps naturally because the warp
    // count is exactly 2**WARP_W.
    function automatic warp_num_t warp_inc(input warp_num_t w);
        return w + 1'b1;
    endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Round-robin search arbiter.
// Finds the first asserted request searching upward from base, wrapping
// at N. Purely combinational so it can be reused by the warp schedulers.
// Ports:
//   req   in  [N-1:0]      request vector
//   base  in  [IDX_W-1:0]  index that has highest priority this cycle
//   grant out [N-1:0]      one-hot grant, all zero when nothing requests
//   idx   out [IDX_W-1:0]  index of the granted requester (0 if none)
module gelato_rr_arbiter #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(base) + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer between decode and issue.
// Decode pushes one entry per cycle into the FIFO of dec_warp; issue pops
// one per cycle from a round-robin selected warp that is non-empty and not
// stalled. Once an offer is not taken, the offer is locked onto that warp
// until it is taken or the warp is flushed.
// Optional build macro GELATO_IBUF_PERF_EN adds perf_issued / perf_idle.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   dec_valid/dec_ready        decode push handshake (dec_ready is full check)
//   dec_warp/dec_inst/dec_pc   push target and payload
//   flush_valid/flush_warp     discard all queued entries of one warp
//   warp_stall                 per-warp issue hazard mask
//   iss_valid/iss_ready        issue pop handshake
//   iss_warp/iss_inst/iss_pc   selected warp and its FIFO head
//   warp_empty                 registered per-warp empty flags
//   perf_issued/perf_idle      (GELATO_IBUF_PERF_EN only) saturating counters
//
// Issue state:
//   state      | meaning
//   ISS_FREE   | arbiter picks the warp each cycle
//   ISS_LOCKED | offer to lock_warp was not taken; keep offering it
module gelato_inst_buffer
    import gelato_inst_buffer_pkg::*;
#(
    parameter int NUM_WARPS = NUM_WARPS_DEF,
    parameter int DEPTH     = IBUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  warp_num_t            dec_warp,
    input  gelato_inst_t         dec_inst,
    input  addr_t                dec_pc,
    input  logic                 flush_valid,
    input  warp_num_t            flush_warp,
    input  logic [NUM_WARPS-1:0] warp_stall,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output warp_num_t            iss_warp,
    output gelato_inst_t         iss_inst,
    output addr_t                iss_pc,
    output logic [NUM_WARPS-1:0] warp_empty
`ifdef GELATO_IBUF_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_idle
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t                 count_q [NUM_WARPS];
    cnt_t                 count_d [NUM_WARPS];
    ptr_t                 head_q  [NUM_WARPS];
    ptr_t                 head_d  [NUM_WARPS];
    ptr_t                 tail_q  [NUM_WARPS];
    ptr_t                 tail_d  [NUM_WARPS];
    ibuf_entry_t          mem_q   [NUM_WARPS][DEPTH];
    ibuf_entry_t          mem_d   [NUM_WARPS][DEPTH];
    warp_num_t            rr_ptr_q, rr_ptr_d;
    warp_num_t            lock_warp_q, lock_warp_d;
    iss_state_e           state_q, state_d;
    logic [NUM_WARPS-1:0] warp_empty_q, warp_empty_d;

    logic [NUM_WARPS-1:0] nonempty;
    logic [NUM_WARPS-1:0] elig;
    logic [NUM_WARPS-1:0] arb_grant;
    warp_num_t            arb_idx;
    warp_num_t            sel_warp;
    logic                 sel_valid;
    logic                 flush_sel;
    logic                 handshake;
    logic                 push;
    logic                 push_keep;
    logic [NUM_WARPS-1:0] push_vec;
    logic [NUM_WARPS-1:0] pop_vec;
    logic [NUM_WARPS-1:0] flush_vec;
    ibuf_entry_t          head_ent;

    always_comb begin
        nonempty = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            nonempty[w] = (count_q[w] != '0);
        end
        elig = nonempty & ~warp_stall;
    end

    gelato_rr_arbiter #(
        .N     (NUM_WARPS),
        .IDX_W (WARP_W)
    ) u_arb (
        .req   (elig),
        .base  (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Issue selection. A flush of the selected warp suppresses the offer
    // rather than letting the arbiter fall through to another warp.
    always_comb begin
        sel_warp  = (state_q == ISS_LOCKED) ? lock_warp_q : arb_idx;
        sel_valid = (state_q == ISS_LOCKED) || (|arb_grant);
        flush_sel = flush_valid && sel_valid && (flush_warp == sel_warp);
        iss_valid = sel_valid && !flush_sel;
        iss_warp  = sel_warp;
        head_ent  = mem_q[sel_warp][head_q[sel_warp]];
        iss_inst  = head_ent.inst;
        iss_pc    = head_ent.pc;
        handshake = iss_valid && iss_ready;
    end

    // Full check only; a pop in the same cycle does not free the slot early.
    always_comb begin
        dec_ready = (count_q[dec_warp] != CNT_W'(DEPTH));
        push      = dec_valid && dec_ready;
        push_keep = push && !(flush_valid && (flush_warp == dec_warp));
    end

    always_comb begin
        state_d     = state_q;
        lock_warp_d = lock_warp_q;
        rr_ptr_d    = rr_ptr_q;
        if (handshake) begin
            state_d     = ISS_FREE;
            lock_warp_d = '0;
            rr_ptr_d    = warp_inc(sel_warp);
        end else if (iss_valid) begin
            state_d     = ISS_LOCKED;
            lock_warp_d = sel_warp;
        end else if (flush_sel) begin
            state_d     = ISS_FREE;
            lock_warp_d = '0;
        end
    end

    always_comb begin
        push_vec     = '0;
        pop_vec      = '0;
        flush_vec    = '0;
        warp_empty_d = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            push_vec[w]  = push && (dec_warp == warp_num_t'(w));
            pop_vec[w]   = handshake && (sel_warp == warp_num_t'(w));
            flush_vec[w] = flush_valid && (flush_warp == warp_num_t'(w));
            count_d[w]   = count_q[w];
            head_d[w]    = head_q[w];
            tail_d[w]    = tail_q[w];
            if (flush_vec[w]) begin
                count_d[w] = '0;
                head_d[w]  = '0;
                tail_d[w]  = '0;
            end else begin
                if (push_vec[w]) begin
                    tail_d[w] = tail_q[w] + 1'b1;
                end
                if (pop_vec[w]) begin
                    head_d[w] = head_q[w] + 1'b1;
                end
                count_d[w] = count_q[w] + CNT_W'(push_vec[w]) - CNT_W'(pop_vec[w]);
            end
            warp_empty_d[w] = (count_d[w] == '0);
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push_keep) begin
            mem_d[dec_warp][tail_q[dec_warp]] = '{inst: dec_inst, pc: dec_pc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= '0;
                head_q[w]  <= '0;
                tail_q[w]  <= '0;
            end
            rr_ptr_q     <= '0;
            lock_warp_q  <= '0;
            state_q      <= ISS_FREE;
            warp_empty_q <= '1;
        end else begin
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_warp_q  <= lock_warp_d;
            state_q      <= state_d;
            warp_empty_q <= warp_empty_d;
        end
    end

    // Payload storage needs no reset: every slot is written before its
    // count makes it visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign warp_empty = warp_empty_q;

`ifdef GELATO_IBUF_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_idle_q, perf_idle_d;

    // Idle means work is queued but every non-empty warp is stalled
    // (or the offer was suppressed by a flush).
    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_idle_d   = perf_idle_q;
        if (handshake && (perf_issued_q != 32'hFFFF_FFFF)) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if (!iss_valid && (|nonempty) && (perf_idle_q != 32'hFFFF_FFFF)) begin
            perf_idle_d = perf_idle_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_idle_q   <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_idle_q   <= perf_idle_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_idle   = perf_idle_q;
`endif

endmodule

// File: tb/tb_gelato_inst_buffer.sv
module tb_gelato_inst_buffer;
    import gelato_inst_buffer_pkg::*;

    localparam int NW = NUM_WARPS_DEF;
    localparam int DP = IBUF_DEPTH;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            dec_valid;
    logic            dec_ready;
    warp_num_t       dec_warp;
    gelato_inst_t    dec_inst;
    addr_t           dec_pc;
    logic            flush_valid;
    warp_num_t       flush_warp;
    logic [NW-1:0]   warp_stall;
    logic            iss_valid;
    logic            iss_ready;
    warp_num_t       iss_warp;
    gelato_inst_t    iss_inst;
    addr_t           iss_pc;
    logic [NW-1:0]   warp_empty;
`ifdef GELATO_IBUF_PERF_EN
    logic [31:0]     perf_issued;
    logic [31:0]     perf_idle;
`endif

    gelato_inst_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_warp    (dec_warp),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .flush_valid (flush_valid),
        .flush_warp  (flush_warp),
        .warp_stall  (warp_stall),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_warp    (iss_warp),
        .iss_inst    (iss_inst),
        .iss_pc      (iss_pc),
        .warp_empty  (warp_empty)
`ifdef GELATO_IBUF_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_idle   (perf_idle)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: one queue per warp plus the arbitration rules.
    ibuf_entry_t   mq [NW][$];
    int            m_rr;
    bit            m_lock;
    int            m_lock_w;
    logic [NW-1:0] m_empty;
    longint        m_issued;
    longint        m_idle;
    int            iss_log [$];

    task automatic model_reset();
        for (int w = 0; w < NW; w++) mq[w].delete();
        m_rr = 0; m_lock = 0; m_lock_w = 0; m_empty = '1;
        m_issued = 0; m_idle = 0;
        iss_log.delete();
    endtask

    // Called at the negedge with inputs stable: compare, then advance model.
    task automatic model_eval();
        bit sv, ev, hs, any_ne, exp_ready;
        int sw;
        ibuf_entry_t e;
        exp_ready = (mq[dec_warp].size() != DP);
        chk_eq("dec_ready", dec_ready, exp_ready);
        chk_eq("warp_empty", warp_empty, m_empty);
        sv = 0; sw = 0;
        if (m_lock) begin
            sv = 1; sw = m_lock_w;
        end else begin
            for (int i = 0; i < NW; i++) begin
                int w = (m_rr + i) % NW;
                if (!sv && mq[w].size() > 0 && !warp_stall[w]) begin
                    sv = 1; sw = w;
                end
            end
        end
        ev = sv && !(flush_valid && int'(flush_warp) == sw);
        chk_eq("iss_valid", iss_valid, ev);
        if (ev) begin
            chk_eq("iss_warp", iss_warp, sw);
            chk_eq("iss_pc", iss_pc, mq[sw][0].pc);
            chk_eq("iss_inst", iss_inst, mq[sw][0].inst);
        end
        any_ne = 0;
        for (int w = 0; w < NW; w++) if (mq[w].size() > 0) any_ne = 1;
        if (!ev && any_ne) m_idle++;
        hs = ev && iss_ready;
        if (hs) begin
            e = mq[sw].pop_front();
            m_rr = (sw + 1) % NW;
            m_lock = 0;
            m_issued++;
            iss_log.push_back(sw);
        end else if (ev) begin
            m_lock = 1; m_lock_w = sw;
        end else if (sv) begin
            m_lock = 0;
        end
        if (dec_valid && exp_ready && !(flush_valid && flush_warp == dec_warp))
            mq[dec_warp].push_back('{inst: dec_inst, pc: dec_pc});
        if (flush_valid) mq[flush_warp].delete();
        for (int w = 0; w < NW; w++) m_empty[w] = (mq[w].size() == 0);
    endtask

    task automatic cycle();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_warp = '0; dec_inst = '0; dec_pc = '0;
        flush_valid = 0; flush_warp = '0; warp_stall = '0; iss_ready = 0;
    endtask

    task automatic push(input int w, input logic [31:0] pc);
        dec_valid = 1; dec_warp = warp_num_t'(w); dec_pc = pc;
        dec_inst = gelato_inst_t'($urandom);
        cycle();
        dec_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_iss_valid", iss_valid, 1'b0);
        chk_eq("rst_warp_empty", warp_empty, 16'hFFFF);
        for (int w = 0; w < NW; w++) begin
            dec_warp = warp_num_t'(w);
            #1;
            chk_eq("rst_dec_ready", dec_ready, 1'b1);
        end
        dec_warp = '0;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        do_reset();

        // Full warp and lock hold.
        push(3, 32'h100);
        push(3, 32'h104);
        dec_valid = 1; dec_warp = 4'd3; dec_pc = 32'h108; dec_inst = gelato_inst_t'($urandom);
        #1;
        chk_eq("full_dec_ready", dec_ready, 1'b0);
        cycle();
        dec_valid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_eq("hold_warp", iss_warp, 4'd3);
            chk_eq("hold_pc", iss_pc, 32'h100);
            cycle();
        end
        iss_ready = 1;
        repeat (3) cycle();

        // Round-robin order from rr_ptr=0, then rr_ptr=3.
        do_reset();
        warp_stall = '1;
        push(0, 32'h000); push(1, 32'h010); push(2, 32'h020);
        warp_stall = '0; iss_ready = 1;
        repeat (3) cycle();
        chk_eq("rr_len", iss_log.size(), 3);
        if (iss_log.size() == 3) begin
            chk_eq("rr_order0", iss_log[0], 0);
            chk_eq("rr_order1", iss_log[1], 1);
            chk_eq("rr_order2", iss_log[2], 2);
        end
        iss_log.delete();
        iss_ready = 0; warp_stall = '1;
        push(0, 32'h030); push(4, 32'h040);
        warp_stall = '0; iss_ready = 1;
        repeat (2) cycle();
        chk_eq("rr_after_len", iss_log.size(), 2);
        if (iss_log.size() == 2) begin
            chk_eq("rr_after0", iss_log[0], 4);
            chk_eq("rr_after1", iss_log[1], 0);
        end

        // Stall masking.
        do_reset();
        warp_stall = '1;
        push(1, 32'h110); push(2, 32'h220);
        warp_stall = 16'h0002; iss_ready = 1;
        cycle();
        warp_stall = '0;
        cycle();
        chk_eq("stall_len", iss_log.size(), 2);
        if (iss_log.size() == 2) begin
            chk_eq("stall_first", iss_log[0], 2);
            chk_eq("stall_second", iss_log[1], 1);
        end

        // Flush of a locked warp with a same-cycle push.
        do_reset();
        push(5, 32'h500);
        cycle();
        flush_valid = 1; flush_warp = 4'd5;
        dec_valid = 1; dec_warp = 4'd5; dec_pc = 32'h504;
        #1;
        chk_eq("flush_iss_valid", iss_valid, 1'b0);
        cycle();
        flush_valid = 0; dec_valid = 0;
        #1;
        chk_eq("flush_empty5", warp_empty[5], 1'b1);
        chk_eq("flush_no_issue", iss_valid, 1'b0);
        repeat (2) cycle();

`ifdef GELATO_IBUF_PERF_EN
        do_reset();
        warp_stall = '1;
        push(4, 32'h400); push(5, 32'h500); push(6, 32'h600);
        repeat (8) cycle();
        chk_eq("perf_idle_10", perf_idle, 32'd10);
        warp_stall = '0; iss_ready = 1;
        repeat (3) cycle();
        chk_eq("perf_issued_3", perf_issued, 32'd3);
        chk_eq("perf_idle_hold", perf_idle, 32'd10);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            dec_valid   = ($urandom_range(0, 9) < 6);
            dec_warp    = ($urandom_range(0, 1) == 0) ? warp_num_t'($urandom_range(0, 3))
                                                      : warp_num_t'($urandom);
            dec_inst    = gelato_inst_t'($urandom);
            dec_pc      = $urandom;
            flush_valid = ($urandom_range(0, 19) == 0);
            flush_warp  = warp_num_t'($urandom_range(0, 7));
            warp_stall  = ($urandom_range(0, 2) == 0) ? NW'($urandom) : '0;
            iss_ready   = ($urandom_range(0, 1) == 1);
            cycle();
        end
`ifdef GELATO_IBUF_PERF_EN
        chk_eq("perf_issued_rand", perf_issued, 64'(m_issued));
        chk_eq("perf_idle_rand", perf_idle, 64'(m_idle));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
